speed_cmd_sequencer: RTL and testbench

Command sequencer in front of the sample-rate speed register (the block that holds the audio clock-divider half-cycle count, default 1227, ±5 per step). Merges three raw pushbuttons (with auto-repeat) and a PicoBlaze/keyboard command port into a clean stream of single-cycle `speedUp`/`speedDown`/`speedReset` pulses. Tracks a shadow copy of the half-cycle value so out-of-range steps are never issued.

---
 rtl/speed_pkg.sv | 23 ++
 rtl/speed_cmd_sequencer_btn_repeat.sv | 50 +++++
 rtl/speed_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_speed_cmd_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared types and range constants for the sample-rate speed command sequencer.
package speed_pkg;

   typedef enum logic [1:0] {
      NOP  = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      RST  = 2'b11
   } speed_op_t;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      PULSE,
      GAP
   } speed_state_t;

   localparam logic [31:0] DEFAULT_HC = 32'd1227;
   localparam logic [31:0] STEP       = 32'd5;
   localparam logic [31:0] MIN_HC     = 32'd627;
   localparam logic [31:0] MAX_HC     = 32'd2427;

endpackage

// File: rtl/speed_cmd_sequencer_btn_repeat.sv
// One raw pushbutton: 2-flop synchronizer, registered rising-edge detect and auto-repeat timer.
module btn_repeat #(
   parameter bit          REPEAT_EN    = 1'b1,
   parameter int unsigned REPEAT_DELAY = 25_000_000,
   parameter int unsigned REPEAT_RATE  = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic rep_allow,
   output logic held,
   output logic rise,
   output logic rep
);

   logic        sync1_q, sync2_q, prev_q;
   logic [31:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
      end
   end

   assign held = sync2_q;
   assign rise = sync2_q & ~prev_q;

   // After the initial delay the counter is rewound so later ticks come every REPEAT_RATE.
   always_comb begin
      rep   = 1'b0;
      cnt_d = cnt_q;
      if (!REPEAT_EN || !sync2_q || !rep_allow) begin
         cnt_d = '0;
      end else if (cnt_q == 32'(REPEAT_DELAY - 1)) begin
         rep   = 1'b1;
         cnt_d = 32'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
   end

endmodule

// File: rtl/speed_cmd_sequencer.sv
// Merges buttons and a command port into spaced, range-clamped speedUp/speedDown/speedReset
// pulses while keeping a shadow copy of the speed register's half-cycle count.
module speed_cmd_sequencer
   import speed_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 25_000_000,
   parameter int unsigned REPEAT_RATE  = 5_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_reset,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   output logic        cmd_ready,
   output logic        speedUp,
   output logic        speedDown,
   output logic        speedReset,
   output logic [31:0] hc_shadow,
   output logic        at_min,
   output logic        at_max
);

   speed_state_t state_q, state_d;
   speed_op_t    op_q, op_d;
   logic         pend_up_q, pend_down_q, pend_rst_q;
   logic         clr_up, clr_down, clr_rst;
   logic         set_up, set_down, set_rst;
   logic [31:0]  hc_q, hc_d;
   logic         up_held, up_rise, up_rep;
   logic         dn_held, dn_rise, dn_rep;
   logic         rst_held, rst_rise, rst_rep;
   logic         up_ok, down_ok;
   logic         unused_rst;

   btn_repeat #(
      .REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) u_btn_up (
      .clk(clk), .reset(reset), .btn(btn_up), .rep_allow(~dn_held),
      .held(up_held), .rise(up_rise), .rep(up_rep)
   );

   btn_repeat #(
      .REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) u_btn_down (
      .clk(clk), .reset(reset), .btn(btn_down), .rep_allow(~up_held),
      .held(dn_held), .rise(dn_rise), .rep(dn_rep)
   );

   btn_repeat #(
      .REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) u_btn_reset (
      .clk(clk), .reset(reset), .btn(btn_reset), .rep_allow(1'b0),
      .held(rst_held), .rise(rst_rise), .rep(rst_rep)
   );

   assign unused_rst = rst_held ^ rst_rep;

   // Opposing edges in the same cycle cancel; repeat ticks never coincide (one button held).
   assign set_up   = (up_rise & ~dn_rise) | up_rep;
   assign set_down = (dn_rise & ~up_rise) | dn_rep;
   assign set_rst  = rst_rise;

   assign up_ok   = hc_q >= (MIN_HC + STEP);
   assign down_ok = hc_q <= (MAX_HC - STEP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= INIT;
         op_q        <= NOP;
         pend_up_q   <= 1'b0;
         pend_down_q <= 1'b0;
         pend_rst_q  <= 1'b0;
         hc_q        <= DEFAULT_HC;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         pend_up_q   <= (pend_up_q & ~clr_up) | set_up;
         pend_down_q <= (pend_down_q & ~clr_down) | set_down;
         pend_rst_q  <= (pend_rst_q & ~clr_rst) | set_rst;
         hc_q        <= hc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      hc_d      = hc_q;
      clr_up    = 1'b0;
      clr_down  = 1'b0;
      clr_rst   = 1'b0;
      cmd_ready = 1'b0;
      unique case (state_q)
         // The power-on speedReset is emitted through PULSE so outputs stay low under reset.
         INIT: begin
            op_d    = RST;
            state_d = PULSE;
         end
         IDLE: begin
            if (pend_rst_q) begin
               clr_rst = 1'b1;
               op_d    = RST;
               state_d = PULSE;
            end else if (pend_up_q) begin
               clr_up = 1'b1;
               if (up_ok) begin
                  op_d    = UP;
                  state_d = PULSE;
               end
            end else if (pend_down_q) begin
               clr_down = 1'b1;
               if (down_ok) begin
                  op_d    = DOWN;
                  state_d = PULSE;
               end
            end else begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  unique case (speed_op_t'(cmd_op))
                     UP:   if (up_ok) begin op_d = UP; state_d = PULSE; end
                     DOWN: if (down_ok) begin op_d = DOWN; state_d = PULSE; end
                     RST:  begin op_d = RST; state_d = PULSE; end
                     NOP:  ;
                  endcase
               end
            end
         end
         PULSE: begin
            state_d = GAP;
            unique case (op_q)
               UP:   hc_d = hc_q - STEP;
               DOWN: hc_d = hc_q + STEP;
               RST:  hc_d = DEFAULT_HC;
               NOP:  ;
            endcase
         end
         GAP: state_d = IDLE;
      endcase
   end

   assign speedUp    = (state_q == PULSE) && (op_q == UP);
   assign speedDown  = (state_q == PULSE) && (op_q == DOWN);
   assign speedReset = (state_q == PULSE) && (op_q == RST);
   assign hc_shadow  = hc_q;
   assign at_min     = hc_q == MIN_HC;
   assign at_max     = hc_q == MAX_HC;

endmodule

// File: tb/tb_speed_cmd_sequencer.sv
// Scoreboard bench for speed_cmd_sequencer with shortened auto-repeat timing.
`timescale 1ns/1ps
module tb_speed_cmd_sequencer;
   import speed_pkg::*;

   localparam int unsigned RD = 20;
   localparam int unsigned RR = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic        cmd_ready, speedUp, speedDown, speedReset, at_min, at_max;
   logic [31:0] hc_shadow;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] hc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_hc = 32'd1227;
   logic [63:0] seen_a, seen_b, want_a, want_b;
   bit          acc;

   always #5 clk = ~clk;

   speed_cmd_sequencer #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_reset(btn_reset),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready), .speedUp(speedUp),
      .speedDown(speedDown), .speedReset(speedReset), .hc_shadow(hc_shadow),
      .at_min(at_min), .at_max(at_max)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [1:0] op);
      exp_t e;
      case (op)
         2'd1:    exp_hc = exp_hc - 32'd5;
         2'd2:    exp_hc = exp_hc + 32'd5;
         default: exp_hc = 32'd1227;
      endcase
      e.op = op;
      e.hc = exp_hc;
      exp_q.push_back(e);
   endtask

   // Holds until cmd_ready is seen high before an edge; returns just after that edge.
   task automatic wait_accept(output bit r);
      int n;
      r = 1'b0;
      n = 0;
      while (!r && n < 40) begin
         @(negedge clk);
         r = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic send_cmd(input logic [1:0] op);
      bit fire;
      bit r;
      case (op)
         2'd1:    fire = exp_hc >= 32'd632;
         2'd2:    fire = exp_hc <= 32'd2422;
         2'd3:    fire = 1'b1;
         default: fire = 1'b0;
      endcase
      if (fire) push_exp(op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      wait_accept(r);
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      check("cmd_accept", {31'd0, r}, 32'd1);
      check("pulse_after_accept", {29'd0, speedReset, speedDown, speedUp},
            fire ? (32'd1 << (op - 2'd1)) : 32'd0);
      if (fire) begin
         check("ready_low_n1", {31'd0, cmd_ready}, 32'd0);
         tick(1);
         check("ready_low_n2", {31'd0, cmd_ready}, 32'd0);
      end
   endtask

   // Monitor: every pulse pops one expectation; the shadow is checked once the pulse ends.
   always begin
      logic [1:0] op;
      exp_t       e;
      @(negedge clk);
      if (!reset && (speedUp || speedDown || speedReset)) begin
         op = speedReset ? 2'd3 : (speedDown ? 2'd2 : 2'd1);
         check("pulse_onehot", 32'(speedUp) + 32'(speedDown) + 32'(speedReset), 32'd1);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, op}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_op", {30'd0, op}, {30'd0, e.op});
            @(negedge clk);
            if (!reset) check("hc_after_pulse", hc_shadow, e.hc);
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      tick(3);
      check("rst_speedUp", {31'd0, speedUp}, 32'd0);
      check("rst_speedDown", {31'd0, speedDown}, 32'd0);
      check("rst_speedReset", {31'd0, speedReset}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_hc", hc_shadow, 32'd1227);
      check("rst_at_min", {31'd0, at_min}, 32'd0);
      check("rst_at_max", {31'd0, at_max}, 32'd0);

      push_exp(2'd3);
      #2 reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("ready_cycle%0d", i), {31'd0, cmd_ready}, (i == 3) ? 32'd1 : 32'd0);
      end

      // Walk down to the fastest setting, then one clamped step.
      for (int i = 0; i < 121; i++) send_cmd(2'd1);
      tick(4);
      check("hc_at_min", hc_shadow, 32'd627);
      check("at_min_set", {31'd0, at_min}, 32'd1);
      check("ready_after_clamp", {31'd0, cmd_ready}, 32'd1);

      for (int i = 0; i < 361; i++) send_cmd(2'd2);
      tick(4);
      check("hc_at_max", hc_shadow, 32'd2427);
      check("at_max_set", {31'd0, at_max}, 32'd1);
      check("at_min_clear", {31'd0, at_min}, 32'd0);

      send_cmd(2'd0);
      send_cmd(2'd3);
      tick(4);
      check("hc_cmd_reset", hc_shadow, 32'd1227);

      // Button up and command down collide: button first, command waits.
      push_exp(2'd1);
      push_exp(2'd2);
      btn_up = 1'b1;
      tick(3);
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      check("ready_low_btn_pending", {31'd0, cmd_ready}, 32'd0);
      wait_accept(acc);
      cmd_valid = 1'b0;
      btn_up    = 1'b0;
      check("collide_cmd_accept", {31'd0, acc}, 32'd1);
      tick(10);
      check("hc_after_collide", hc_shadow, 32'd1227);

      // Simultaneous up and down edges cancel.
      btn_up   = 1'b1;
      btn_down = 1'b1;
      tick(5);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      tick(15);
      check("hc_after_cancel", hc_shadow, 32'd1227);

      // Held down: edge pulse, then repeats every RR cycles after the delay.
      want_a = '0;
      want_a[3] = 1'b1; want_a[22] = 1'b1; want_a[30] = 1'b1; want_a[38] = 1'b1;
      repeat (4) push_exp(2'd2);
      seen_a = '0;
      btn_down = 1'b1;
      for (int c = 0; c < 56; c++) begin
         @(posedge clk);
         #1;
         seen_a[c] = speedDown;
         if (c == 40) btn_down = 1'b0;
      end
      check("repeat_down_lo", seen_a[31:0], want_a[31:0]);
      check("repeat_down_hi", seen_a[63:32], want_a[63:32]);
      check("hc_after_repeat", hc_shadow, 32'd1247);

      // Reset button while up is auto-repeating: reset is serviced next.
      want_a = '0;
      want_a[3] = 1'b1; want_a[22] = 1'b1;
      want_b = '0;
      want_b[29] = 1'b1;
      push_exp(2'd1);
      push_exp(2'd1);
      push_exp(2'd3);
      seen_a = '0;
      seen_b = '0;
      btn_up = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         seen_a[c] = speedUp;
         seen_b[c] = speedReset;
         if (c == 25) btn_reset = 1'b1;
         if (c == 26) btn_up = 1'b0;
         if (c == 27) btn_reset = 1'b0;
      end
      check("repeat_up_pattern", seen_a[31:0], want_a[31:0]);
      check("btn_reset_pattern", seen_b[31:0], want_b[31:0]);
      check("hc_after_btn_reset", hc_shadow, 32'd1227);

      // Reset during PULSE drops the pulse and loses the request.
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      wait_accept(acc);
      cmd_valid = 1'b0;
      check("pulse_before_reset", {31'd0, speedDown}, 32'd1);
      reset = 1'b1;
      #1;
      check("pulse_drops_on_reset", {31'd0, speedDown}, 32'd0);
      check("hc_on_reset", hc_shadow, 32'd1227);
      exp_hc = 32'd1227;
      push_exp(2'd3);
      tick(2);
      #2 reset = 1'b0;
      tick(5);
      check("ready_after_rereset", {31'd0, cmd_ready}, 32'd1);

      for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick(1);
      tick(2);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
